// File: rtl/arb_mux_reg.sv
// Registered N-channel arbitrating mux with valid/ready on every port.
// Optional output stall counter enabled by defining ARB_MUX_STALL_CNT_EN.
module arb_mux_reg #(
   parameter int BITS = 8,
   parameter int CH   = 4,
   parameter int SW   = $clog2(CH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               mode,
   input  logic [SW-1:0]      sel,
   input  logic [CH-1:0]      in_valid,
   input  logic [CH*BITS-1:0] in_data,
   output logic [CH-1:0]      in_ready,
   output logic               out_valid,
   output logic [BITS-1:0]    out_data,
   output logic [SW-1:0]      out_ch,
   input  logic               out_ready,
   output logic [15:0]        stall_cnt
);

   logic [SW-1:0]   rr;
   logic [CH-1:0]   grant;
   logic [SW-1:0]   gnt_idx;
   logic            found;
   logic [BITS-1:0] win_data;
   logic            load;
   logic            in_xfer;
   int              idx;

   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      if (mode) begin
         // an out-of-range sel simply matches no channel
         for (int i = 0; i < CH; i++) begin
            if (sel == SW'(i) && in_valid[i]) begin
               grant[i] = 1'b1;
               gnt_idx  = SW'(i);
               found    = 1'b1;
            end
         end
      end else begin
         for (int k = 0; k < CH; k++) begin
            idx = (int'(rr) + k) % CH;
            if (!found && in_valid[idx]) begin
               grant[idx] = 1'b1;
               gnt_idx    = SW'(idx);
               found      = 1'b1;
            end
         end
      end
   end

   always_comb begin
      win_data = '0;
      for (int i = 0; i < CH; i++) begin
         if (grant[i]) win_data = in_data[i*BITS +: BITS];
      end
   end

   assign load     = !out_valid || out_ready;
   assign in_xfer  = load && found;
   // rst_n gating keeps in_ready low while reset is held, even though the register reads empty
   assign in_ready = (rst_n && load) ? grant : '0;

   // Output register stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         rr        <= '0;
      end else if (in_xfer) begin
         out_valid <= 1'b1;
         out_data  <= win_data;
         out_ch    <= gnt_idx;
         if (!mode) rr <= (gnt_idx == SW'(CH-1)) ? '0 : gnt_idx + SW'(1);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef ARB_MUX_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (out_valid && !out_ready && stall_q != 16'hFFFF) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_arb_mux_reg.sv
// Self-checking bench for arb_mux_reg (CH=4, BITS=8) against a behavioural model.
module tb_arb_mux_reg;

   localparam int CH   = 4;
   localparam int BITS = 8;
`ifdef ARB_MUX_STALL_CNT_EN
   localparam int EXP_BP_STALL = 5;
`else
   localparam int EXP_BP_STALL = 0;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            mode = 1'b0;
   logic [1:0]      sel = '0;
   logic [CH-1:0]   in_valid = '0;
   logic [CH*BITS-1:0] in_data = '0;
   logic [CH-1:0]   in_ready;
   logic            out_valid;
   logic [BITS-1:0] out_data;
   logic [1:0]      out_ch;
   logic            out_ready = 1'b1;
   logic [15:0]     stall_cnt;

   int total = 0;
   int bad   = 0;

   // reference model state
   int         rr_m;
   bit         ov_m;
   logic [7:0] od_m;
   int         oc_m;
   int         st_m;
   int         acc;

   arb_mux_reg #(.BITS(BITS), .CH(CH)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
      .out_ready(out_ready), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Winner according to the arbitration rules, or -1 for no grant.
   function automatic int pick();
      if (mode) begin
         if (int'(sel) < CH && in_valid[int'(sel)]) return int'(sel);
         return -1;
      end
      for (int k = 0; k < CH; k++) begin
         if (in_valid[(rr_m + k) % CH]) return (rr_m + k) % CH;
      end
      return -1;
   endfunction

   task automatic cycle();
      int g;
      bit ld;
      logic [CH-1:0] exp_rdy;
      #1;
      g  = pick();
      ld = !ov_m || out_ready;
      exp_rdy = '0;
      if (ld && g >= 0) exp_rdy[g] = 1'b1;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      @(posedge clk);
      if (ov_m && !out_ready && st_m < 16'hFFFF) begin
`ifdef ARB_MUX_STALL_CNT_EN
         st_m++;
`endif
      end
      if (ld && g >= 0) begin
         ov_m = 1'b1;
         od_m = in_data[g*BITS +: BITS];
         oc_m = g;
         if (!mode) rr_m = (g + 1) % CH;
         acc = g;
      end else begin
         acc = -1;
         if (ov_m && out_ready) ov_m = 1'b0;
      end
      #1;
      chk("out_valid", 32'(out_valid), 32'(ov_m));
      chk("out_data", 32'(out_data), 32'(od_m));
      chk("out_ch", 32'(out_ch), 32'(oc_m));
      chk("stall_cnt", 32'(stall_cnt), 32'(st_m));
   endtask

   // Asserts reset asynchronously, checks the cleared state, releases at negedge.
   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = '1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_ch", 32'(out_ch), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_stall", 32'(stall_cnt), 32'd0);
      rr_m = 0; ov_m = 1'b0; od_m = '0; oc_m = 0; st_m = 0; acc = -1;
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = '0;
   endtask

   initial begin
      int exp_seq[6];
      exp_seq = '{0, 1, 2, 3, 0, 1};

      // power-on reset
      @(negedge clk);
      do_reset();

      // round-robin fairness: all valid, consumer always ready
      mode = 1'b0; out_ready = 1'b1;
      in_data  = {8'h33, 8'h22, 8'h11, 8'h00};
      in_valid = 4'hF;
      for (int i = 0; i < 6; i++) begin
         cycle();
         chk("rr_seq", 32'(out_ch), 32'(exp_seq[i]));
         chk("rr_full_tput", 32'(out_valid), 32'd1);
      end

      // skip idle channels 0 and 2
      in_valid = 4'b1010;
      in_data  = {8'hA3, 8'h00, 8'hA1, 8'h00};
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("skip_no_ch0_ch2", 32'(in_ready & 4'b0101), 32'd0);
      end

      // forced select of channel 2, then resume round-robin
      in_valid = 4'hF;
      in_data  = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
      mode = 1'b1; sel = 2'd2;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("forced_data", 32'(out_data), 32'h0000_00D2);
      end
      mode = 1'b0;
      cycle();
      cycle();

      // back-pressure for 5 cycles with a full output register
      @(negedge clk);
      do_reset();
      in_valid = 4'hF;
      in_data  = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("bp_hold_data", 32'(out_data), 32'h0000_00B0);
      end
      chk("bp_stall", 32'(stall_cnt), 32'(EXP_BP_STALL));
      out_ready = 1'b1;
      cycle();
      chk("bp_no_bubble_valid", 32'(out_valid), 32'd1);
      chk("bp_no_bubble_data", 32'(out_data), 32'h0000_00B1);

      // reset mid-stream while holding 8'h5C
      in_valid = 4'b0100;
      in_data  = {8'h00, 8'h5C, 8'h00, 8'h00};
      cycle();
      chk("mid_held", 32'(out_data), 32'h0000_005C);
      do_reset();
      in_valid = 4'hF;
      in_data  = {8'hE3, 8'hE2, 8'hE1, 8'hE0};
      cycle();
      chk("mid_restart_ch0", 32'(out_ch), 32'd0);

      // randomized traffic; producers hold requests until accepted
      for (int n = 0; n < 400; n++) begin
         for (int c = 0; c < CH; c++) begin
            if (!in_valid[c] || acc == c) begin
               in_valid[c] = 1'($urandom_range(0, 1));
               in_data[c*BITS +: BITS] = 8'($urandom);
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) begin
            mode = ~mode;
            sel  = 2'($urandom_range(0, 3));
         end
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
